// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// instruction field positions and the PC increment.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } ifu_state_e;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    localparam int PC_STEP   = 4;

endpackage

// File: rtl/ifu_if.sv
// Instruction-memory read bus: req/addr held until ack; rdata valid with ack.
interface ifu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/ifu_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO of {pc, instr}.
// Flush has priority over push and pop.
module ifu_fifo #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] push_pc_i,
    input  logic [DATA_W-1:0] push_instr_i,
    output logic [ADDR_W-1:0] head_pc_o,
    output logic [DATA_W-1:0] head_instr_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o
);

    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem_q[wr_ptr_q]    <= push_pc_i;
            instr_mem_q[wr_ptr_q] <= push_instr_i;
        end
    end

    assign head_pc_o    = pc_mem_q[rd_ptr_q];
    assign head_instr_o = instr_mem_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, single-outstanding imem reads, prefetch FIFO and
// redirect flush. Define IFU_PERF_CNT_EN to add fetched/stall counters.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    ifu_if.master             imem,
    // Decode handshake: the head transfers on a rising edge where
    // instr_valid_o & instr_ready_i; the head is held stable while valid & !ready.
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic [5:0]        op_o,
    output logic [5:0]        funct_o,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [1:0]        state_o
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched_o,
    output logic [31:0]       perf_stall_o
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_DROP = DROP;

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty, fifo_full;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_instr;

    logic              ack, push, pop;
    logic [ADDR_W-1:0] redirect_pc_aligned;
    logic [ADDR_W-1:0] pc_next;
    logic [CNT_W:0]    count_after;
    logic              room;

    assign ack  = imem.imem_ack & req_q;
    assign pop  = instr_valid_o & instr_ready_i & ~redirect_valid_i;
    assign push = (state_q == S_WAIT) & ack & ~redirect_valid_i;

    assign redirect_pc_aligned = redirect_pc_i & ~ADDR_W'(3);
    assign pc_next             = fetch_pc_q + ADDR_W'(PC_STEP);

    // Room for another outstanding request once this cycle's push and pop settle.
    assign count_after = {1'b0, fifo_count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
    assign room        = count_after < (CNT_W+1)'(FIFO_DEPTH);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            S_IDLE: begin
                if (redirect_valid_i) begin
                    fetch_pc_d = redirect_pc_aligned;
                end else if (!fifo_full) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end
            S_WAIT: begin
                if (redirect_valid_i) begin
                    fetch_pc_d = redirect_pc_aligned;
                    if (ack) begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (ack) begin
                    fetch_pc_d = pc_next;
                    if (room) begin
                        addr_d = pc_next;
                    end else begin
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            S_DROP: begin
                // Stale request stays on the bus until the memory answers it.
                if (redirect_valid_i) fetch_pc_d = redirect_pc_aligned;
                if (ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    ifu_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (redirect_valid_i),
        .push_pc_i    (addr_q),
        .push_instr_i (imem.imem_rdata),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr),
        .count_o      (fifo_count),
        .empty_o      (fifo_empty),
        .full_o       (fifo_full)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    assign instr_valid_o = ~fifo_empty;
    assign instr_o       = head_instr;
    assign instr_pc_o    = head_pc;
    assign op_o          = head_instr[OP_MSB:OP_LSB];
    assign funct_o       = head_instr[FUNCT_MSB:FUNCT_LSB];
    assign state_o       = state_q;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_stall_q;

    // Counters survive redirects; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (instr_valid_o & instr_ready_i)  perf_fetched_q <= perf_fetched_q + 32'd1;
            if (~instr_valid_o & instr_ready_i) perf_stall_q   <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetched_o = perf_fetched_q;
    assign perf_stall_o   = perf_stall_q;
`endif

endmodule
